// File: rtl/pipe_regfile_pkg.sv
// Shared types and default widths for the pipe_regfile block.
package pipe_regfile_pkg;

    localparam int DEF_INDEX_BIT_WIDTH = 4;
    localparam int DEF_DATA_BIT_WIDTH  = 32;

    // CLEAR sweeps RESET_VALUE through the array; RUN is normal operation.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/pipe_regfile_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue,
// cleared on load writeback (set wins on a same-index collision).
// Stall lookups read only the registered bits.
module pipe_regfile_scoreboard #(
    parameter int INDEX_BIT_WIDTH = 4,
    parameter int N_REGS          = 1 << INDEX_BIT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en_i,
    input  logic                       set_i,
    input  logic [INDEX_BIT_WIDTH-1:0] set_idx_i,
    input  logic                       clr_i,
    input  logic [INDEX_BIT_WIDTH-1:0] clr_idx_i,
    input  logic [INDEX_BIT_WIDTH-1:0] rd_idx1_i,
    input  logic [INDEX_BIT_WIDTH-1:0] rd_idx2_i,
    output logic                       pend1_o,
    output logic                       pend2_o
);

    logic [N_REGS-1:0] pending_q, pending_d;

    // Next pending vector: clear first so a same-index set overrides it.
    always_comb begin
        pending_d = pending_q;
        if (en_i) begin
            if (clr_i) pending_d[clr_idx_i] = 1'b0;
            if (set_i) pending_d[set_idx_i] = 1'b1;
        end
    end

    // Pending register, wiped by reset.
    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign pend1_o = pending_q[rd_idx1_i];
    assign pend2_o = pending_q[rd_idx2_i];

endmodule

// File: rtl/pipe_regfile.sv
// Decode-stage register file: 2 combinational reads, 1 write, post-reset
// clear sweep and pending-load stall flags.
// Optional macro PIPE_REGFILE_FORWARD_EN: same-cycle bypass of non-load
// writes onto the read ports.
module pipe_regfile
    import pipe_regfile_pkg::*;
#(
    parameter int INDEX_BIT_WIDTH                 = DEF_INDEX_BIT_WIDTH,
    parameter int DATA_BIT_WIDTH                  = DEF_DATA_BIT_WIDTH,
    parameter int N_REGS                          = 1 << INDEX_BIT_WIDTH,
    parameter logic [DATA_BIT_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wrtEn,
    input  logic [INDEX_BIT_WIDTH-1:0] wrtIndex,
    input  logic [DATA_BIT_WIDTH-1:0]  dataIn,
    input  logic                       wrtIsLoad,
    input  logic [INDEX_BIT_WIDTH-1:0] rdIndex1,
    input  logic [INDEX_BIT_WIDTH-1:0] rdIndex2,
    output logic [DATA_BIT_WIDTH-1:0]  dataOut1,
    output logic [DATA_BIT_WIDTH-1:0]  dataOut2,
    input  logic                       pendSet,
    input  logic [INDEX_BIT_WIDTH-1:0] pendIndex,
    output logic                       stall1,
    output logic                       stall2,
    output logic                       clearing
);

    localparam logic [INDEX_BIT_WIDTH-1:0] LAST_IDX = INDEX_BIT_WIDTH'(N_REGS - 1);

    rf_state_e                  state_q, state_d;
    logic [INDEX_BIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_BIT_WIDTH-1:0]  regs_q [N_REGS];
    logic                       run;
    logic                       pend1, pend2;

    assign run      = (state_q == RUN);
    assign clearing = ~run;

    // Sweep walks the counter once over every index, then hands over to RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
    end

    // FSM state and sweep counter; reset restarts the sweep from index 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array write: sweep owns the port in CLEAR, writeback owns it in RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!run)       regs_q[cnt_q]    <= RESET_VALUE;
            else if (wrtEn) regs_q[wrtIndex] <= dataIn;
        end
    end

    // Read ports; loads are never bypassed since their data arrives late.
    always_comb begin
        dataOut1 = regs_q[rdIndex1];
        dataOut2 = regs_q[rdIndex2];
`ifdef PIPE_REGFILE_FORWARD_EN
        if (wrtEn && !wrtIsLoad && wrtIndex == rdIndex1) dataOut1 = dataIn;
        if (wrtEn && !wrtIsLoad && wrtIndex == rdIndex2) dataOut2 = dataIn;
`endif
        if (!run) begin
            dataOut1 = RESET_VALUE;
            dataOut2 = RESET_VALUE;
        end
    end

    pipe_regfile_scoreboard #(
        .INDEX_BIT_WIDTH (INDEX_BIT_WIDTH),
        .N_REGS          (N_REGS)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .en_i      (run),
        .set_i     (pendSet),
        .set_idx_i (pendIndex),
        .clr_i     (wrtEn & wrtIsLoad),
        .clr_idx_i (wrtIndex),
        .rd_idx1_i (rdIndex1),
        .rd_idx2_i (rdIndex2),
        .pend1_o   (pend1),
        .pend2_o   (pend2)
    );

    assign stall1 = pend1 | ~run;
    assign stall2 = pend2 | ~run;

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: stimulus pushes expectations for the
// current cycle, a negedge monitor pops and compares them.
module tb_pipe_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        wrtEn, wrtIsLoad, pendSet;
    logic [3:0]  wrtIndex, rdIndex1, rdIndex2, pendIndex;
    logic [31:0] dataIn, dataOut1, dataOut2;
    logic        stall1, stall2, clearing;

    always #5 clk = ~clk;

    pipe_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .wrtEn     (wrtEn),
        .wrtIndex  (wrtIndex),
        .dataIn    (dataIn),
        .wrtIsLoad (wrtIsLoad),
        .rdIndex1  (rdIndex1),
        .rdIndex2  (rdIndex2),
        .dataOut1  (dataOut1),
        .dataOut2  (dataOut2),
        .pendSet   (pendSet),
        .pendIndex (pendIndex),
        .stall1    (stall1),
        .stall2    (stall2),
        .clearing  (clearing)
    );

    // kind: 0 dataOut1, 1 dataOut2, 2 stall1, 3 stall2, 4 clearing
    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef PIPE_REGFILE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic expect_v(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic idle();
        wrtEn = 1'b0; wrtIsLoad = 1'b0; wrtIndex = '0; dataIn = '0;
        pendSet = 1'b0; pendIndex = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation queued for this cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                0:       act = dataOut1;
                1:       act = dataOut2;
                2:       act = {31'd0, stall1};
                3:       act = {31'd0, stall2};
                default: act = {31'd0, clearing};
            endcase
            n_cmp++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
            end
        end
    end

    // Sweep cycles with writes/pendSet hammering (must be ignored), then a
    // full readback of every index expecting zero data and no stalls.
    task automatic sweep_and_readback(input string tag);
        for (int i = 0; i < 16; i++) begin
            wrtEn = 1'b1; wrtIndex = 4'd4; dataIn = 32'hAAAA_AAAA; wrtIsLoad = 1'b0;
            pendSet = 1'b1; pendIndex = 4'd9;
            rdIndex1 = 4'(i); rdIndex2 = 4'd9;
            expect_v(4, 1, {tag, "_clearing"});
            expect_v(2, 1, {tag, "_sweep_stall1"});
            expect_v(3, 1, {tag, "_sweep_stall2"});
            expect_v(0, 0, {tag, "_sweep_dout1"});
            expect_v(1, 0, {tag, "_sweep_dout2"});
            step();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            rdIndex1 = 4'(i); rdIndex2 = 4'(15 - i);
            expect_v(4, 0, {tag, "_run_clearing"});
            expect_v(0, 0, {tag, "_rd1_zero"});
            expect_v(1, 0, {tag, "_rd2_zero"});
            expect_v(2, 0, {tag, "_stall1_clear"});
            expect_v(3, 0, {tag, "_stall2_clear"});
            step();
        end
    endtask

    initial begin
        idle();
        rdIndex1 = '0; rdIndex2 = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        sweep_and_readback("s1");

        // Non-load write to r5: bypass only in the forwarding build.
        wrtEn = 1'b1; wrtIndex = 4'd5; dataIn = 32'hDEAD_BEEF; rdIndex1 = 4'd5;
        expect_v(0, FWD ? 32'hDEAD_BEEF : 32'h0, "r5_same_cycle");
        step();
        idle(); rdIndex1 = 4'd5;
        expect_v(0, 32'hDEAD_BEEF, "r5_next_cycle");
        step();

        // Load writeback r3: never forwarded.
        wrtEn = 1'b1; wrtIsLoad = 1'b1; wrtIndex = 4'd3; dataIn = 32'h1234_5678;
        rdIndex2 = 4'd3;
        expect_v(1, 32'h0, "ld_r3_same_cycle");
        expect_v(0, 32'hDEAD_BEEF, "r5_hold");
        step();
        idle(); rdIndex2 = 4'd3;
        expect_v(1, 32'h1234_5678, "ld_r3_next_cycle");
        step();

        // Write r6 while reading r5: no false bypass.
        wrtEn = 1'b1; wrtIndex = 4'd6; dataIn = 32'h0000_0066; rdIndex1 = 4'd5;
        expect_v(0, 32'hDEAD_BEEF, "no_false_fwd");
        step();

        // Pending load on r7.
        idle(); pendSet = 1'b1; pendIndex = 4'd7; rdIndex1 = 4'd7;
        expect_v(2, 0, "r7_stall_issue_cycle");
        step();
        idle(); rdIndex1 = 4'd7;
        expect_v(2, 1, "r7_stall_set");
        step();
        wrtEn = 1'b1; wrtIsLoad = 1'b1; wrtIndex = 4'd7; dataIn = 32'h0000_0077;
        expect_v(2, 1, "r7_stall_wb_cycle");
        expect_v(0, 0, "r7_ld_not_fwd");
        step();
        idle(); rdIndex1 = 4'd7;
        expect_v(2, 0, "r7_stall_cleared");
        expect_v(0, 32'h0000_0077, "r7_data");
        step();

        // Same-cycle set and clear on r2: set wins.
        pendSet = 1'b1; pendIndex = 4'd2;
        wrtEn = 1'b1; wrtIsLoad = 1'b1; wrtIndex = 4'd2; dataIn = 32'h0000_0022;
        rdIndex2 = 4'd2;
        expect_v(3, 0, "r2_stall_before");
        step();
        idle(); rdIndex2 = 4'd2;
        expect_v(3, 1, "r2_set_wins");
        expect_v(1, 32'h0000_0022, "r2_data");
        step();
        pendSet = 1'b1; pendIndex = 4'd10; rdIndex2 = 4'd2;
        expect_v(3, 1, "r2_still_pending");
        step();
        idle(); rdIndex1 = 4'd10;
        expect_v(2, 1, "r10_pending");
        step();

        // Mid-run reset: fresh sweep, everything zero, no stalls.
        reset = 1'b1;
        step();
        reset = 1'b0;
        sweep_and_readback("s2");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
